// File: rtl/tank_pkg.sv
// Shared definitions for the tank level indicator.
//   DEFAULT_DEBOUNCE_CYCLES : default debounce length in clocks
//   debounce_cnt_width()    : counter width able to hold 0..cycles
package tank_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

  // Width of a counter that must represent values up to 'cycles'.
  function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = unsigned'($clog2(cycles + 1));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tank_level_indicator_sync_2ff.sv
// Generic 1-bit two-flop synchronizer, async active-low reset to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d_i   : asynchronous input
//   q_o   : synchronized output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; only the second flop is observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tank_level_indicator.sv
// Tank level LED driver: synchronizes and debounces one level sensor.
//   clock       : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   tank_sensor : raw asynchronous sensor input, may bounce
//   led         : registered debounced level (1 = liquid present)
//   led_changed : registered one-cycle pulse when led toggles
module tank_level_indicator
  import tank_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          SENSOR_ACTIVE_HIGH = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tank_sensor,
  output logic led,
  output logic led_changed
);

  localparam int unsigned CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s_in;
  logic             sync2;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             chg_q, chg_d;

  // Polarity fix-up ahead of the synchronizer so downstream logic is always active-high.
  assign s_in = SENSOR_ACTIVE_HIGH ? tank_sensor : ~tank_sensor;

  sync_2ff u_sync (
    .clk   (clock),
    .rst_n (reset_n),
    .d_i   (s_in),
    .q_o   (sync2)
  );

  // Debounce: count consecutive disagreeing cycles; any agreement clears the count.
  always_comb begin
    cnt_d = '0;
    led_d = led_q;
    chg_d = 1'b0;
    if (sync2 != led_q) begin
      if (cnt_q == CNT_LAST) begin
        led_d = sync2;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      led_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
      chg_q <= chg_d;
    end
  end

  assign led         = led_q;
  assign led_changed = chg_q;

endmodule

// File: tb/tb_tank_level_indicator.sv
// Self-checking bench for tank_level_indicator: default, active-low and
// single-cycle-debounce instances driven from vector tables and short sequences.
module tb_tank_level_indicator;

  logic clk = 1'b0;
  logic reset_n;
  logic s_def, s_al, s_d1;
  logic led_def, chg_def, led_al, chg_al, led_d1, chg_d1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tank_level_indicator u_def (
    .clock(clk), .reset_n(reset_n), .tank_sensor(s_def),
    .led(led_def), .led_changed(chg_def)
  );

  tank_level_indicator #(.DEBOUNCE_CYCLES(4), .SENSOR_ACTIVE_HIGH(1'b0)) u_al (
    .clock(clk), .reset_n(reset_n), .tank_sensor(s_al),
    .led(led_al), .led_changed(chg_al)
  );

  tank_level_indicator #(.DEBOUNCE_CYCLES(1), .SENSOR_ACTIVE_HIGH(1'b1)) u_d1 (
    .clock(clk), .reset_n(reset_n), .tank_sensor(s_d1),
    .led(led_d1), .led_changed(chg_d1)
  );

  typedef struct packed {
    logic s;
    logic led;
    logic chg;
  } vec_t;

  typedef struct {
    int    sel;
    logic  led;
    logic  chg;
    string name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  function automatic void add_vec(input logic s, input logic l, input logic c);
    vec_t v;
    v.s = s; v.led = l; v.chg = c;
    vecs.push_back(v);
  endfunction

  function automatic void sb_push(input int sel, input logic l, input logic c, input string name);
    sb_t e;
    e.sel = sel; e.led = l; e.chg = c; e.name = name;
    sb.push_back(e);
  endfunction

  task automatic check_pop();
    sb_t  e;
    logic al, ac;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry available");
      return;
    end
    e = sb.pop_front();
    case (e.sel)
      0:       begin al = led_def; ac = chg_def; end
      1:       begin al = led_al;  ac = chg_al;  end
      default: begin al = led_d1;  ac = chg_d1;  end
    endcase
    if ({al, ac} !== {e.led, e.chg}) begin
      errors++;
      $display("FAIL %s (dut%0d): got led=%b led_changed=%b, expected led=%b led_changed=%b",
               e.name, e.sel, al, ac, e.led, e.chg);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    s_def   = 1'b1;
    s_al    = 1'b1;
    s_d1    = 1'b0;

    // Default instance, sensor applied before edge j; expectations after edge j.
    for (int j = 0; j < 8; j++)  add_vec(1'b1, j >= 5, j == 5); // clean rise, k=0
    for (int j = 0; j < 8; j++)  add_vec(1'b0, j < 5,  j == 5); // clean fall
    for (int j = 0; j < 8; j++)  add_vec(j < 3, 1'b0, 1'b0);    // 3-clock glitch
    for (int j = 0; j < 10; j++) add_vec(j % 2 == 0, 1'b0, 1'b0); // toggling
    for (int j = 0; j < 4; j++)  add_vec(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    // Reset held with sensor asserted: outputs stay low.
    for (int j = 0; j < 4; j++) begin
      sb_push(0, 1'b0, 1'b0, "reset_hold");
      @(negedge clk);
      check_pop();
    end

    s_def   = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      s_def = vecs[i].s;
      sb_push(0, vecs[i].led, vecs[i].chg, $sformatf("vec%0d", i));
      @(negedge clk);
      check_pop();
    end

    // Active-low sensor: drive 0 = liquid present.
    s_al = 1'b0;
    for (int j = 0; j < 8; j++) begin
      sb_push(1, j >= 5, j == 5, $sformatf("active_low_e%0d", j));
      @(negedge clk);
      check_pop();
    end

    // Single-cycle debounce: led follows sync2 one edge later.
    s_d1 = 1'b1;
    for (int j = 0; j < 5; j++) begin
      sb_push(2, j >= 2, j == 2, $sformatf("db1_e%0d", j));
      @(negedge clk);
      check_pop();
    end

    // Bring the default instance high again for the async reset check.
    s_def = 1'b1;
    for (int j = 0; j < 7; j++) begin
      sb_push(0, j >= 5, j == 5, $sformatf("rerise_e%0d", j));
      @(negedge clk);
      check_pop();
    end

    // Async reset mid-cycle: leds drop with no clock edge in between.
    #2;
    reset_n = 1'b0;
    #1;
    sb_push(0, 1'b0, 1'b0, "async_reset_def");
    sb_push(1, 1'b0, 1'b0, "async_reset_al");
    sb_push(2, 1'b0, 1'b0, "async_reset_d1");
    check_pop();
    check_pop();
    check_pop();

    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      sb_push(0, 1'b0, 1'b0, "reset_hold_end");
      check_pop();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tank_level_indicator.md
Name: tank_level_indicator

Overview:
- Drives a single tank-level LED from one digital level sensor.
- The raw sensor input is asynchronous. It passes through a 2-flop synchronizer and then a debounce filter before it reaches a registered LED output.
- Sits between the board-level sensor pin and the front-panel LED driver.
- Also provides a one-cycle change pulse for status/interrupt logic.

Parameters:
- DEBOUNCE_CYCLES, default 4. Number of consecutive clocks the synchronized sensor must differ from the current stable level before the LED changes. Legal range 1..65535.
- SENSOR_ACTIVE_HIGH, default 1. 1: tank_sensor=1 means liquid present. 0: tank_sensor=0 means liquid present (input inverted before the synchronizer).

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- tank_sensor  input  1  raw level sensor, asynchronous to clock, may bounce
- led  output  1  registered; 1 = tank level reached (LED on)
- led_changed  output  1  registered; one-cycle pulse when led toggles

Behaviour:
- Reset (reset_n=0, asynchronous): sync stage 1 and stage 2 = 0, debounce counter = 0, led = 0, led_changed = 0. Release is synchronous to the next clock edge (normal flop behaviour).
- Polarity: s_in = tank_sensor when SENSOR_ACTIVE_HIGH=1, else ~tank_sensor. Inversion happens before the first flop.
- Synchronizer: sync1 <= s_in; sync2 <= sync1. Only sync2 feeds later logic.
- Debounce counter: width clog2(DEBOUNCE_CYCLES+1).
  - If sync2 == led: counter <= 0.
  - If sync2 != led and counter == DEBOUNCE_CYCLES-1: led <= sync2; counter <= 0; led_changed <= 1.
  - If sync2 != led otherwise: counter <= counter+1.
  - led_changed is 0 in every cycle where led does not toggle.
- Latency: s_in changes and is held stable before clock edge k. sync1 captures at edge k and sync2 at edge k+1. led changes at edge k+1+DEBOUNCE_CYCLES. With the default of 4, that is edge k+5. With DEBOUNCE_CYCLES=1, led follows sync2 one edge later (edge k+2).
- Glitch rejection: any return of sync2 to equal led before the count completes clears the counter. A pulse shorter than DEBOUNCE_CYCLES clocks never reaches led.
- A toggling input: if the input toggles every clock and DEBOUNCE_CYCLES >= 2, led holds its value indefinitely.
- The counter never exceeds DEBOUNCE_CYCLES-1 and does not wrap.
- Reset mid-count: reset_n low at any time abandons the count, and led returns to 0 immediately (asynchronously).
- There is no combinational path from tank_sensor to any output.

Decomposition:
- Shared package tank_pkg: DEFAULT_DEBOUNCE_CYCLES = 4, and a function returning the counter width.
- One natural sub-module: sync_2ff, a generic 1-bit two-flop synchronizer with async active-low reset and reset value 0. Instantiate it once on s_in.
- The debounce and LED logic stay in the top module.

Test Plan:
- Reset: hold reset_n=0 with tank_sensor=1 -> led=0 and led_changed=0 throughout; assert reset_n=0 while led=1 -> led=0 without waiting for a clock edge.
- Clean rise, default params: tank_sensor 0->1 before edge k, held -> led=1 at edge k+5; led_changed=1 for exactly that one cycle, 0 otherwise.
- Clean fall: from led=1, tank_sensor 1->0 held -> led=0 five edges after the first sampling edge, with one led_changed pulse.
- Glitch rejection: tank_sensor high for 3 clocks, then low (DEBOUNCE_CYCLES=4) -> led stays 0 and led_changed never asserts.
- Toggling input: tank_sensor inverted every clock for 10 cycles -> led constant 0 and led_changed constant 0.
- Parameter variants:
  - SENSOR_ACTIVE_HIGH=0: tank_sensor held 0 -> led=1 after 5 edges.
  - DEBOUNCE_CYCLES=1: rise -> led=1 at edge k+2.
